hdmi_video_pattern_gen: RTL and testbench

Generates CEA-861 1080p60 video timing (1920x1080 active, 2200x1125 total) and an 8-bar colour-bar test pattern.
Drives the parallel RGB/sync interface of the HDMI transmitter.
Clocked by the 148.5 MHz pixel clock from the PLL; reset is held low until the PLL reports lock.

---
 rtl/hdmi_video_pattern_gen.sv | 115 +++++++++++
 tb/tb_hdmi_video_pattern_gen.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/hdmi_video_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_video_pattern_gen
// Brief    : 1080p60 video timing generator with an 8-bar colour-bar pattern
//            for the parallel RGB/sync port of the HDMI transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module hdmi_video_pattern_gen #(
  parameter int   H_ACTIVE = 1920,
  parameter int   H_FP     = 88,
  parameter int   H_SYNC   = 44,
  parameter int   H_BP     = 148,
  parameter int   V_ACTIVE = 1080,
  parameter int   V_FP     = 4,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 36,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_de,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b
);

  localparam int          c_h_total  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int          c_v_total  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [11:0] c_h_last   = 12'(c_h_total - 1);
  localparam logic [11:0] c_v_last   = 12'(c_v_total - 1);
  localparam logic [11:0] c_h_act    = 12'(H_ACTIVE);
  localparam logic [11:0] c_v_act    = 12'(V_ACTIVE);
  localparam logic [11:0] c_hs_start = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] c_hs_end   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] c_vs_start = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] c_vs_end   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] c_bar_last = 12'(H_ACTIVE / 8 - 1);

  logic [11:0] r_h_cnt;
  logic [11:0] r_v_cnt;
  logic [11:0] r_bar_px;
  logic [2:0]  r_bar_idx;

  logic        w_h_wrap;
  logic        w_de;
  logic        w_hs;
  logic        w_vs;
  logic [7:0]  w_r;
  logic [7:0]  w_g;
  logic [7:0]  w_b;

  assign w_h_wrap = (r_h_cnt == c_h_last);
  assign w_de     = (r_h_cnt < c_h_act) && (r_v_cnt < c_v_act);
  assign w_hs     = (r_h_cnt >= c_hs_start) && (r_h_cnt < c_hs_end);
  assign w_vs     = (r_v_cnt >= c_vs_start) && (r_v_cnt < c_vs_end);

  // Bar order white..black makes each channel a single inverted index bit:
  // red drops on bit 1, green on bit 2, blue on bit 0.
  assign w_r = (w_de && !r_bar_idx[1]) ? 8'hFF : 8'h00;
  assign w_g = (w_de && !r_bar_idx[2]) ? 8'hFF : 8'h00;
  assign w_b = (w_de && !r_bar_idx[0]) ? 8'hFF : 8'h00;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h_cnt <= 12'd0;
      r_v_cnt <= 12'd0;
    end else begin
      if (w_h_wrap) begin
        r_h_cnt <= 12'd0;
        r_v_cnt <= (r_v_cnt == c_v_last) ? 12'd0 : r_v_cnt + 12'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 12'd1;
      end
    end
  end

  // Bar position tracks h_cnt in lock-step so the bar index needs no divider.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bar_px  <= 12'd0;
      r_bar_idx <= 3'd0;
    end else if (w_h_wrap) begin
      r_bar_px  <= 12'd0;
      r_bar_idx <= 3'd0;
    end else if (r_bar_px == c_bar_last) begin
      r_bar_px  <= 12'd0;
      r_bar_idx <= r_bar_idx + 3'd1;
    end else begin
      r_bar_px  <= r_bar_px + 12'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_de <= 1'b0;
      vga_hs <= ~HS_POL;
      vga_vs <= ~VS_POL;
      vga_r  <= 8'h00;
      vga_g  <= 8'h00;
      vga_b  <= 8'h00;
    end else begin
      vga_de <= w_de;
      vga_hs <= w_hs ? HS_POL : ~HS_POL;
      vga_vs <= w_vs ? VS_POL : ~VS_POL;
      vga_r  <= w_r;
      vga_g  <= w_g;
      vga_b  <= w_b;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hdmi_video_pattern_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_hdmi_video_pattern_gen
// Brief    : Self-checking bench: full-size 1080p instance plus a short-frame
//            instance, both compared every pixel against a pixel-index model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hdmi_video_pattern_gen;

  localparam int c_s_va = 4;
  localparam int c_s_vf = 1;
  localparam int c_s_vs = 2;
  localparam int c_s_vb = 1;
  localparam int c_s_frame = 2200 * (c_s_va + c_s_vf + c_s_vs + c_s_vb);

  logic       clk;
  logic       reset_n;
  logic       f_hs, f_vs, f_de;
  logic [7:0] f_r, f_g, f_b;
  logic       s_hs, s_vs, s_de;
  logic [7:0] s_r, s_g, s_b;

  int     n_assert;
  int     n_fail;
  longint pix;   // index of the pixel currently shown, -1 while in reset

  hdmi_video_pattern_gen dut_full (
    .clk(clk), .reset_n(reset_n),
    .vga_hs(f_hs), .vga_vs(f_vs), .vga_de(f_de),
    .vga_r(f_r), .vga_g(f_g), .vga_b(f_b)
  );

  hdmi_video_pattern_gen #(
    .V_ACTIVE(c_s_va), .V_FP(c_s_vf), .V_SYNC(c_s_vs), .V_BP(c_s_vb)
  ) dut_small (
    .clk(clk), .reset_n(reset_n),
    .vga_hs(s_hs), .vga_vs(s_vs), .vga_de(s_de),
    .vga_r(s_r), .vga_g(s_g), .vga_b(s_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {de,hs,vs,rgb} for pixel p of a frame built from the raster rules.
  function automatic logic [26:0] model(input longint p, input int va, input int vf,
                                        input int vs, input int vb);
    int          ht;
    int          vt;
    int          q;
    int          x;
    int          y;
    logic        de;
    logic        h;
    logic        v;
    logic [23:0] rgb;
    if (p < 0) return 27'd0;
    ht  = 1920 + 88 + 44 + 148;
    vt  = va + vf + vs + vb;
    q   = int'(p % longint'(ht * vt));
    x   = q % ht;
    y   = q / ht;
    de  = (x < 1920) && (y < va);
    h   = (x >= 2008) && (x < 2052);
    v   = (y >= va + vf) && (y < va + vf + vs);
    rgb = 24'h000000;
    if (de) begin
      case (x / 240)
        0: rgb = 24'hFFFFFF;
        1: rgb = 24'hFFFF00;
        2: rgb = 24'h00FFFF;
        3: rgb = 24'h00FF00;
        4: rgb = 24'hFF00FF;
        5: rgb = 24'hFF0000;
        6: rgb = 24'h0000FF;
        default: rgb = 24'h000000;
      endcase
    end
    return {de, h, v, rgb};
  endfunction

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
  endtask

  task automatic check(input string tag, input logic [26:0] obs, input logic [26:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s pix=%0d observed={de,hs,vs,rgb}=%h expected=%h", tag, pix, obs, exp);
    end
    if (n_fail >= 25) begin
      $display("aborting: too many errors");
      summary();
      $finish;
    end
  endtask

  task automatic check_both(input string tag);
    check({tag, "_full"},  {f_de, f_hs, f_vs, f_r, f_g, f_b}, model(pix, 1080, 4, 5, 36));
    check({tag, "_small"}, {s_de, s_hs, s_vs, s_r, s_g, s_b},
          model(pix, c_s_va, c_s_vf, c_s_vs, c_s_vb));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (reset_n) pix++;
    @(negedge clk);
    check_both(tag);
  endtask

  // Assert reset between edges and confirm outputs clear without a clock.
  task automatic async_reset(input string tag);
    #2 reset_n = 1'b0;
    #1 pix = -1;
    check_both(tag);
    repeat ($urandom_range(1, 5)) step({tag, "_hold"});
    reset_n = 1'b1;
  endtask

  initial begin
    int target;
    int guard;
    n_assert = 0;
    n_fail   = 0;
    pix      = -1;
    reset_n  = 1'b0;

    repeat (4) step("reset");
    reset_n = 1'b1;

    // First line plus the start of the second: de window, bars, hs pulse.
    repeat (2300) step("line0");

    repeat ($urandom_range(50, 2000)) step("midline");
    async_reset("async_midline");

    // Two short frames and one extra line: vs window and frame wrap.
    repeat (2 * c_s_frame + 2200) step("frames");

    // Reset landing inside the vsync lines of the short frame.
    target = 2200 * (c_s_va + c_s_vf) + $urandom_range(0, 2200 * c_s_vs - 1);
    guard  = 0;
    while ((int'(pix % longint'(c_s_frame)) != target) && (guard < c_s_frame + 10)) begin
      step("to_vsync");
      guard++;
    end
    n_assert++;
    assert (s_vs === 1'b1) else begin
      n_fail++;
      $error("FAIL vsync_reached observed vs=%b expected=1 after %0d steps", s_vs, guard);
    end
    async_reset("async_vsync");
    repeat (2300) step("after_vsync_reset");

    summary();
    $finish;
  end

endmodule
`default_nettype wire
